// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I sequencing controller: a Moore FSM that drives datapath selects,
// write strobes and the unified memory handshake, and counts retired instructions.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_write,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [2:0]  imm_src,
    output logic        illegal,
    output logic [31:0] instret
);

    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_OP      = 7'b0110011;
    localparam logic [6:0] OP_OPIMM   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OP_MISCMEM = 7'b0001111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR_ADR = 4'd11,
        S_AUIPC    = 4'd12,
        S_LUI      = 4'd13,
        S_HALT     = 4'd14
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instret_q;
    logic        illegal_q;
    logic        retire_s;
    logic        mem_req_s, mem_write_s, ir_write_s, pc_write_s, reg_write_s;

    // Next-state, retire and per-state control decode
    always_comb begin
        state_d     = state_q;
        retire_s    = 1'b0;
        mem_req_s   = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        pc_write_s  = 1'b0;
        reg_write_s = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_req_s  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    state_d    = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                // OldPC + imm lands in ALUOut for branch/JAL targets
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE:     state_d = S_MEMADR;
                    OP_OP:                 state_d = S_EXEC_R;
                    OP_OPIMM:              state_d = S_EXEC_I;
                    OP_BRANCH:             state_d = S_BRANCH;
                    OP_JAL:                state_d = S_JAL;
                    OP_JALR:               state_d = S_JALR_ADR;
                    OP_AUIPC:              state_d = S_AUIPC;
                    OP_LUI:                state_d = S_LUI;
                    OP_SYSTEM, OP_MISCMEM: begin
                        state_d  = S_FETCH;
                        retire_s = 1'b1;
                    end
                    default:               state_d = S_HALT;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                if (op == OP_STORE) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                mem_req_s = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_s = 1'b1;
                retire_s    = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_s   = 1'b1;
                mem_write_s = 1'b1;
                adr_src     = 1'b1;
                if (mem_ready) begin
                    retire_s = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                retire_s    = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                pc_write_s = branch_taken;
                retire_s   = 1'b1;
                state_d    = S_FETCH;
            end
            S_JALR_ADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = S_JAL;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while the ALU forms OldPC + 4 for rd
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write_s = 1'b1;
                state_d    = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                state_d   = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                state_d   = S_ALUWB;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Immediate format follows the opcode regardless of state
    always_comb begin
        case (op)
            OP_LOAD, OP_OPIMM, OP_JALR: imm_src = 3'b000;
            OP_STORE:                   imm_src = 3'b001;
            OP_BRANCH:                  imm_src = 3'b010;
            OP_JAL:                     imm_src = 3'b011;
            OP_AUIPC, OP_LUI:           imm_src = 3'b100;
            default:                    imm_src = 3'b000;
        endcase
    end

    assign mem_req   = mem_req_s   & rst_n;
    assign mem_write = mem_write_s & rst_n;
    assign ir_write  = ir_write_s  & rst_n;
    assign pc_write  = pc_write_s  & rst_n;
    assign reg_write = reg_write_s & rst_n;
    assign illegal   = illegal_q;
    assign instret   = instret_q;

    // State, retire counter and sticky illegal flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            instret_q <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire_s) begin
                instret_q <= instret_q + 32'd1;
            end
            if (state_d == S_HALT) begin
                illegal_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed per-cycle vectors push expected
// outputs into a queue; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  op;
    logic        branch_taken;
    logic        mem_ready;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0]  imm_src;
    logic        illegal;
    logic [31:0] instret;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
        .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    // ctrl = {mem_req,mem_write,adr_src,ir_write,pc_write,reg_write,result_src,alu_src_a,alu_src_b,alu_op}
    localparam logic [13:0] C_FETCH_W  = {6'b100000, 2'b10, 2'b00, 2'b10, 2'b00};
    localparam logic [13:0] C_FETCH_R  = {6'b100110, 2'b10, 2'b00, 2'b10, 2'b00};
    localparam logic [13:0] C_FETCH_RS = {6'b000000, 2'b10, 2'b00, 2'b10, 2'b00};
    localparam logic [13:0] C_DECODE   = {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00};
    localparam logic [13:0] C_MEMADR   = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00};
    localparam logic [13:0] C_MEMREAD  = {6'b101000, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [13:0] C_MEMRD_RS = {6'b001000, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [13:0] C_MEMWB    = {6'b000001, 2'b01, 2'b00, 2'b00, 2'b00};
    localparam logic [13:0] C_MEMWRITE = {6'b111000, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [13:0] C_EXEC_R   = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b10};
    localparam logic [13:0] C_EXEC_I   = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b10};
    localparam logic [13:0] C_ALUWB    = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [13:0] C_BR_T     = {6'b000010, 2'b00, 2'b10, 2'b00, 2'b01};
    localparam logic [13:0] C_BR_N     = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b01};
    localparam logic [13:0] C_JALR_ADR = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00};
    localparam logic [13:0] C_JAL      = {6'b000010, 2'b00, 2'b01, 2'b10, 2'b00};
    localparam logic [13:0] C_AUIPC    = {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00};
    localparam logic [13:0] C_LUI      = {6'b000000, 2'b00, 2'b11, 2'b01, 2'b00};
    localparam logic [13:0] C_HALT     = 14'd0;

    typedef struct {
        string       name;
        logic [13:0] ctrl;
        logic [2:0]  imm;
        logic        ill;
        logic [31:0] ret;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [2:0]  exp_imm;
    logic        exp_ill;
    logic [31:0] exp_ret;

    // Monitor: every cycle the DUT presents a full output vector; compare against the queue head
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t        e;
            logic [13:0] act;
            e   = sb_q.pop_front();
            act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                   result_src, alu_src_a, alu_src_b, alu_op};
            n_vec++;
            if (act !== e.ctrl || imm_src !== e.imm || illegal !== e.ill || instret !== e.ret) begin
                n_miss++;
                $display("FAIL %s: got ctrl=%b imm=%b ill=%b ret=%0d, want ctrl=%b imm=%b ill=%b ret=%0d",
                         e.name, act, imm_src, illegal, instret, e.ctrl, e.imm, e.ill, e.ret);
            end
        end
    end

    task automatic step(input string nm, input logic [6:0] o, input logic br,
                        input logic rdy, input logic rn, input logic [13:0] c);
        exp_t e;
        @(posedge clk);
        #1;
        op           = o;
        branch_taken = br;
        mem_ready    = rdy;
        rst_n        = rn;
        e.name = nm;
        e.ctrl = c;
        e.imm  = exp_imm;
        e.ill  = exp_ill;
        e.ret  = exp_ret;
        sb_q.push_back(e);
    endtask

    localparam logic [6:0] ADD   = 7'b0110011;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] BR    = 7'b1100011;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] OPI   = 7'b0010011;
    localparam logic [6:0] AUI   = 7'b0010111;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] SYS   = 7'b1110011;
    localparam logic [6:0] BAD   = 7'b1111111;

    initial begin
        rst_n = 1'b0; op = ADD; branch_taken = 1'b0; mem_ready = 1'b0;
        exp_imm = 3'b000; exp_ill = 1'b0; exp_ret = 32'd0;
        repeat (2) @(posedge clk);
        step("reset_hold", ADD, 1'b0, 1'b1, 1'b0, C_FETCH_RS);

        // R-type ADD, 4 cycles
        step("add_fetch",  ADD, 1'b0, 1'b1, 1'b1, C_FETCH_R);
        step("add_decode", ADD, 1'b0, 1'b1, 1'b1, C_DECODE);
        step("add_exec",   ADD, 1'b0, 1'b1, 1'b1, C_EXEC_R);
        step("add_wb",     ADD, 1'b0, 1'b1, 1'b1, C_ALUWB);
        exp_ret = 32'd1;

        // LOAD with two wait cycles in FETCH and MEMREAD, 9 cycles
        step("ld_fetch_w1", LOAD, 1'b0, 1'b0, 1'b1, C_FETCH_W);
        step("ld_fetch_w2", LOAD, 1'b0, 1'b0, 1'b1, C_FETCH_W);
        step("ld_fetch",    LOAD, 1'b0, 1'b1, 1'b1, C_FETCH_R);
        step("ld_decode",   LOAD, 1'b0, 1'b1, 1'b1, C_DECODE);
        step("ld_memadr",   LOAD, 1'b0, 1'b1, 1'b1, C_MEMADR);
        step("ld_mrd_w1",   LOAD, 1'b0, 1'b0, 1'b1, C_MEMREAD);
        step("ld_mrd_w2",   LOAD, 1'b0, 1'b0, 1'b1, C_MEMREAD);
        step("ld_mrd",      LOAD, 1'b0, 1'b1, 1'b1, C_MEMREAD);
        step("ld_memwb",    LOAD, 1'b0, 1'b1, 1'b1, C_MEMWB);
        exp_ret = 32'd2;

        // STORE, 4 cycles
        exp_imm = 3'b001;
        step("st_fetch",  STORE, 1'b0, 1'b1, 1'b1, C_FETCH_R);
        step("st_decode", STORE, 1'b0, 1'b1, 1'b1, C_DECODE);
        step("st_memadr", STORE, 1'b0, 1'b1, 1'b1, C_MEMADR);
        step("st_memwr",  STORE, 1'b0, 1'b1, 1'b1, C_MEMWRITE);
        exp_ret = 32'd3;

        // Branch taken then not taken, 3 cycles each
        exp_imm = 3'b010;
        step("bt_fetch",  BR, 1'b1, 1'b1, 1'b1, C_FETCH_R);
        step("bt_decode", BR, 1'b1, 1'b1, 1'b1, C_DECODE);
        step("bt_branch", BR, 1'b1, 1'b1, 1'b1, C_BR_T);
        exp_ret = 32'd4;
        step("bn_fetch",  BR, 1'b0, 1'b1, 1'b1, C_FETCH_R);
        step("bn_decode", BR, 1'b0, 1'b1, 1'b1, C_DECODE);
        step("bn_branch", BR, 1'b0, 1'b1, 1'b1, C_BR_N);
        exp_ret = 32'd5;

        // JALR, 5 cycles
        exp_imm = 3'b000;
        step("jalr_fetch",  JALR, 1'b0, 1'b1, 1'b1, C_FETCH_R);
        step("jalr_decode", JALR, 1'b0, 1'b1, 1'b1, C_DECODE);
        step("jalr_adr",    JALR, 1'b0, 1'b1, 1'b1, C_JALR_ADR);
        step("jalr_jal",    JALR, 1'b0, 1'b1, 1'b1, C_JAL);
        step("jalr_wb",     JALR, 1'b0, 1'b1, 1'b1, C_ALUWB);
        exp_ret = 32'd6;

        // JAL, OP-IMM, AUIPC, LUI: 4 cycles each
        exp_imm = 3'b011;
        step("jal_fetch",  JAL, 1'b0, 1'b1, 1'b1, C_FETCH_R);
        step("jal_decode", JAL, 1'b0, 1'b1, 1'b1, C_DECODE);
        step("jal_jal",    JAL, 1'b0, 1'b1, 1'b1, C_JAL);
        step("jal_wb",     JAL, 1'b0, 1'b1, 1'b1, C_ALUWB);
        exp_ret = 32'd7;
        exp_imm = 3'b000;
        step("opi_fetch",  OPI, 1'b0, 1'b1, 1'b1, C_FETCH_R);
        step("opi_decode", OPI, 1'b0, 1'b1, 1'b1, C_DECODE);
        step("opi_exec",   OPI, 1'b0, 1'b1, 1'b1, C_EXEC_I);
        step("opi_wb",     OPI, 1'b0, 1'b1, 1'b1, C_ALUWB);
        exp_ret = 32'd8;
        exp_imm = 3'b100;
        step("aui_fetch",  AUI, 1'b0, 1'b1, 1'b1, C_FETCH_R);
        step("aui_decode", AUI, 1'b0, 1'b1, 1'b1, C_DECODE);
        step("aui_exec",   AUI, 1'b0, 1'b1, 1'b1, C_AUIPC);
        step("aui_wb",     AUI, 1'b0, 1'b1, 1'b1, C_ALUWB);
        exp_ret = 32'd9;
        step("lui_fetch",  LUI, 1'b0, 1'b1, 1'b1, C_FETCH_R);
        step("lui_decode", LUI, 1'b0, 1'b1, 1'b1, C_DECODE);
        step("lui_exec",   LUI, 1'b0, 1'b1, 1'b1, C_LUI);
        step("lui_wb",     LUI, 1'b0, 1'b1, 1'b1, C_ALUWB);
        exp_ret = 32'd10;

        // SYSTEM as NOP, 2 cycles
        exp_imm = 3'b000;
        step("nop_fetch",  SYS, 1'b0, 1'b1, 1'b1, C_FETCH_R);
        step("nop_decode", SYS, 1'b0, 1'b1, 1'b1, C_DECODE);
        exp_ret = 32'd11;

        // Reset during a MEMREAD stall aborts the access
        step("rl_fetch",  LOAD, 1'b0, 1'b1, 1'b1, C_FETCH_R);
        step("rl_decode", LOAD, 1'b0, 1'b1, 1'b1, C_DECODE);
        step("rl_memadr", LOAD, 1'b0, 1'b1, 1'b1, C_MEMADR);
        step("rl_mrd_w",  LOAD, 1'b0, 1'b0, 1'b1, C_MEMREAD);
        step("rl_rst",    LOAD, 1'b0, 1'b0, 1'b0, C_MEMRD_RS);
        exp_ret = 32'd0;
        step("rl_after",  LOAD, 1'b0, 1'b0, 1'b1, C_FETCH_W);
        step("rl_fetch2", LOAD, 1'b0, 1'b1, 1'b1, C_FETCH_R);
        step("rl_decode2", LOAD, 1'b0, 1'b1, 1'b1, C_DECODE);
        step("rl_memadr2", LOAD, 1'b0, 1'b1, 1'b1, C_MEMADR);
        step("rl_mrd2",   LOAD, 1'b0, 1'b1, 1'b1, C_MEMREAD);
        step("rl_memwb2", LOAD, 1'b0, 1'b1, 1'b1, C_MEMWB);
        exp_ret = 32'd1;

        // Illegal opcode: HALT is sticky, no requests, instret frozen
        step("ill_fetch",  BAD, 1'b0, 1'b1, 1'b1, C_FETCH_R);
        step("ill_decode", BAD, 1'b0, 1'b1, 1'b1, C_DECODE);
        exp_ill = 1'b1;
        for (int i = 0; i < 22; i++) begin
            step("ill_halt", BAD, i[0], i[1], 1'b1, C_HALT);
        end
        step("ill_rst", BAD, 1'b0, 1'b1, 1'b0, C_HALT);
        exp_ill = 1'b0;
        exp_ret = 32'd0;
        step("ill_cleared", ADD, 1'b0, 1'b0, 1'b1, C_FETCH_W);

        for (int k = 0; k < 10 && sb_q.size() > 0; k++) begin
            @(posedge clk);
        end
        if (sb_q.size() > 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending, want 0 pending", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Sequencing controller for the multicycle RV32I core variant that shares one unified instruction/data memory port. A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback. It drives every datapath select and write strobe, handshakes with the memory port, flags illegal opcodes and counts retired instructions.

## Interface
- No parameters.
- clk  in  1  core clock
- rst_n  in  1  synchronous, active-low reset
- op  in  7  opcode field of the instruction register
- branch_taken  in  1  branch condition result from the comparator, valid in BRANCH
- mem_ready  in  1  memory port completes the current access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  the request is a store
- adr_src  out  1  memory address select: 0=PC, 1=ALUOut
- ir_write  out  1  load IR and OldPC
- pc_write  out  1  load PC from the result bus
- reg_write  out  1  register file write enable
- result_src  out  2  result select: 00=ALUOut, 01=MemData, 10=ALUResult
- alu_src_a  out  2  ALU A select: 00=PC, 01=OldPC, 10=rs1 latch, 11=zero
- alu_src_b  out  2  ALU B select: 00=rs2 latch, 01=immediate, 10=constant 4
- alu_op  out  2  ALU operation: 00=add, 01=subtract/compare, 10=decode from funct fields
- imm_src  out  3  immediate format: I=000, S=001, B=010, J=011, U=100
- illegal  out  1  sticky flag for an unsupported opcode
- instret  out  32  count of retired instructions

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, JALR_ADR, AUIPC, LUI, HALT.
- Any output not listed for a state is 0. Selects not listed for a state are also 0.
- imm_src is a pure function of op in every state:
  - LOAD, OP-IMM, JALR → I
  - STORE → S
  - BRANCH → B
  - JAL → J
  - AUIPC, LUI → U
  - any other opcode → 000
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - When mem_ready=1: ir_write=1 and pc_write=1, next state is DECODE.
  - Otherwise the FSM holds in FETCH.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00. This computes the branch/JAL target into ALUOut. Next state by op:
  - LOAD or STORE → MEMADR
  - OP → EXEC_R
  - OP-IMM → EXEC_I
  - BRANCH → BRANCH
  - JAL → JAL
  - JALR → JALR_ADR
  - AUIPC → AUIPC
  - LUI → LUI
  - SYSTEM or MISC-MEM → FETCH (executed as a NOP, retires)
  - anything else → HALT
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next state is MEMREAD for LOAD, MEMWRITE for STORE.
- MEMREAD: mem_req=1, adr_src=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1. Next state FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Holds until mem_ready=1, then goes to FETCH.
- EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10. Next state ALUWB.
- EXEC_I: alu_src_a=10, alu_src_b=01, alu_op=10. Next state ALUWB.
- ALUWB: result_src=00, reg_write=1. Next state FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00. pc_write equals branch_taken. Next state FETCH.
- JALR_ADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next state JAL.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1. Next state ALUWB, which writes OldPC+4 to rd.
- AUIPC: alu_src_a=01, alu_src_b=01, alu_op=00. Next state ALUWB.
- LUI: alu_src_a=11, alu_src_b=01, alu_op=00. Next state ALUWB.
- HALT: illegal=1, all strobes are 0, and the FSM stays in HALT until reset.
- instret increments by 1 in the cycle the FSM leaves MEMWB, ALUWB, BRANCH, or MEMWRITE (with mem_ready=1), and on the DECODE→FETCH NOP path. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset: a clock edge with rst_n=0 puts the FSM in FETCH and clears instret and illegal to 0.
- While rst_n=0, mem_req, mem_write, ir_write, pc_write and reg_write are forced to 0.
- Reset mid-access (for example while waiting in MEMREAD) aborts the access. The first cycle after release is FETCH with mem_req=1.
- All outputs except the illegal and instret registers are combinational from the state and inputs. There is no output register.
- Latency with mem_ready=1 every cycle:
  - R/I-type, AUIPC, LUI, JAL: 4 cycles
  - load and JALR: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
  - NOP: 2 cycles
- Each memory wait cycle adds exactly one cycle to the instruction.
- mem_req stays high and adr_src stays stable until mem_ready=1. mem_ready sampled while mem_req=0 is ignored.

## Test plan
- R-type ADD with mem_ready tied to 1 → FETCH, DECODE, EXEC_R, ALUWB. reg_write=1 only in cycle 4, and instret goes 0→1.
- LOAD with mem_ready low for 2 cycles in both FETCH and MEMREAD → 9 cycles total. ir_write pulses once, and result_src=01 during MEMWB.
- BRANCH: once with branch_taken=1, then repeated with branch_taken=0 → pc_write is 1 then 0 in the BRANCH cycle. Both take 3 cycles.
- JALR → the sequence includes JALR_ADR then JAL, pc_write=1 in JAL, reg_write=1 in ALUWB, total 5 cycles.
- op=7'b1111111 → HALT. illegal=1 persists with no mem_req for 20+ cycles, and instret is unchanged. Asserting rst_n=0 clears it.
- Reset asserted during a MEMREAD stall → the next cycle is FETCH, with mem_write=0 and instret=0.
